// File: rtl/enoc_node_interface_pkg.sv
// Shared ENoC definitions: address/time widths, the packet layout and a
// saturating counter helper used by the node interface statistics.
package enoc_node_interface_pkg;

  localparam int unsigned ADDRESS_WIDTH = 8;
  localparam int unsigned TIME_WIDTH    = 16;
  localparam int unsigned DATA_WIDTH    = 32;

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [TIME_WIDTH-1:0]    time_t;

  typedef struct packed {
    addr_t                 source;
    addr_t                 dest;
    time_t                 timestamp;
    logic [DATA_WIDTH-1:0] data;
  } packet_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/enoc_fifo.sv
// Synchronous packet FIFO with registered occupancy. A push while full is
// dropped even if a pop happens in the same cycle (no bypass). The head
// output reads as all-zero while the FIFO is empty.
module enoc_fifo
  import enoc_node_interface_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  packet_t push_data,
  input  logic    pop,
  output packet_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  packet_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/enoc_node_interface.sv
// Node-side network interface: stamps locally injected packets with source
// and injection time, queues them towards the network, queues packets from
// the network towards the local sink, and keeps traffic statistics.
module enoc_node_interface
  import enoc_node_interface_pkg::*;
#(
  parameter addr_t       NODE_ID  = '0,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  packet_t               i_inj_data,
  input  logic                  i_inj_val,
  output logic                  o_inj_rdy,
  output packet_t               o_data,
  output logic                  o_data_val,
  input  logic                  i_en,
  input  packet_t               i_data,
  input  logic                  i_data_val,
  output logic                  o_en,
  output packet_t               o_ej_data,
  output logic                  o_ej_val,
  input  logic                  i_ej_rdy,
  output logic [31:0]           o_tx_count,
  output logic [31:0]           o_rx_count,
  output logic [TIME_WIDTH-1:0] o_last_latency,
  output logic                  o_misroute
);

  time_t   time_cnt;
  packet_t tx_entry;
  logic    tx_full;
  logic    tx_empty;
  logic    tx_pop;
  logic    rx_full;
  logic    rx_empty;
  logic    rx_push;
  logic    rx_pop;

  // Free-running local time base, wraps modulo 2^TIME_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) time_cnt <= '0;
    else       time_cnt <= time_cnt + TIME_WIDTH'(1);
  end

  // Injected packet keeps dest/data; source and timestamp are owned by this node.
  always_comb begin
    tx_entry           = i_inj_data;
    tx_entry.source    = NODE_ID;
    tx_entry.timestamp = time_cnt;
  end

  assign o_inj_rdy  = ~tx_full;
  assign o_data_val = ~tx_empty;
  assign tx_pop     = o_data_val & i_en;

  enoc_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (i_inj_val),
    .push_data (tx_entry),
    .pop       (tx_pop),
    .head      (o_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // o_en depends only on registered occupancy, so no path from i_en/i_ej_rdy.
  assign o_en     = ~rx_full;
  assign rx_push  = i_data_val & o_en;
  assign o_ej_val = ~rx_empty;
  assign rx_pop   = o_ej_val & i_ej_rdy;

  enoc_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (i_data),
    .pop       (rx_pop),
    .head      (o_ej_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Traffic statistics: saturating counts, last latency and sticky misroute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_tx_count     <= '0;
      o_rx_count     <= '0;
      o_last_latency <= '0;
      o_misroute     <= 1'b0;
    end else begin
      if (tx_pop) o_tx_count <= sat_inc(o_tx_count);
      if (rx_push) begin
        o_rx_count     <= sat_inc(o_rx_count);
        o_last_latency <= time_cnt - i_data.timestamp;
        if (i_data.dest != NODE_ID) o_misroute <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_enoc_node_interface.sv
// Scoreboard bench for enoc_node_interface: expected packets are queued when
// a handshake is driven and compared when the DUT presents them.
module tb_enoc_node_interface;
  import enoc_node_interface_pkg::*;

  localparam addr_t NID = 8'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  packet_t     i_inj_data;
  logic        i_inj_val;
  logic        o_inj_rdy;
  packet_t     o_data;
  logic        o_data_val;
  logic        i_en;
  packet_t     i_data;
  logic        i_data_val;
  logic        o_en;
  packet_t     o_ej_data;
  logic        o_ej_val;
  logic        i_ej_rdy;
  logic [31:0] o_tx_count;
  logic [31:0] o_rx_count;
  time_t       o_last_latency;
  logic        o_misroute;

  enoc_node_interface #(.NODE_ID(NID), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_inj_data     (i_inj_data),
    .i_inj_val      (i_inj_val),
    .o_inj_rdy      (o_inj_rdy),
    .o_data         (o_data),
    .o_data_val     (o_data_val),
    .i_en           (i_en),
    .i_data         (i_data),
    .i_data_val     (i_data_val),
    .o_en           (o_en),
    .o_ej_data      (o_ej_data),
    .o_ej_val       (o_ej_val),
    .i_ej_rdy       (i_ej_rdy),
    .o_tx_count     (o_tx_count),
    .o_rx_count     (o_rx_count),
    .o_last_latency (o_last_latency),
    .o_misroute     (o_misroute)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference time base: equals the DUT counter between edges.
  time_t tb_time;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_time <= '0;
    else       tb_time <= tb_time + 16'd1;
  end

  packet_t     tx_q[$];
  packet_t     rx_q[$];
  logic [31:0] m_tx;
  logic [31:0] m_rx;
  time_t       m_lat;
  logic        m_mis;
  packet_t     mon_p;

  // Monitor: state checks reflect past edges, then predict the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_tx  = '0;
      m_rx  = '0;
      m_lat = '0;
      m_mis = 1'b0;
    end else begin
      check("tx_count", o_tx_count, m_tx);
      check("rx_count", o_rx_count, m_rx);
      check("latency", o_last_latency, m_lat);
      check("misroute", o_misroute, m_mis);
      if (o_data_val && i_en) begin
        if (tx_q.size() == 0) check("tx_unexpected", o_data, '0);
        else                  check("tx_pkt", o_data, tx_q.pop_front());
        m_tx = m_tx + 32'd1;
      end
      if (o_ej_val && i_ej_rdy) begin
        if (rx_q.size() == 0) check("ej_unexpected", o_ej_data, '0);
        else                  check("ej_pkt", o_ej_data, rx_q.pop_front());
      end
      if (i_inj_val && o_inj_rdy) begin
        mon_p           = i_inj_data;
        mon_p.source    = NID;
        mon_p.timestamp = tb_time;
        tx_q.push_back(mon_p);
      end
      if (i_data_val && o_en) begin
        rx_q.push_back(i_data);
        m_rx  = m_rx + 32'd1;
        m_lat = tb_time - i_data.timestamp;
        if (i_data.dest != NID) m_mis = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inj(input addr_t dest, input logic [31:0] data);
    i_inj_data      = '0;
    i_inj_data.dest = dest;
    i_inj_data.data = data;
    i_inj_val       = 1'b1;
  endtask

  task automatic set_rx(input addr_t dest, input time_t ts, input logic [31:0] data);
    i_data           = '0;
    i_data.source    = 8'd9;
    i_data.dest      = dest;
    i_data.timestamp = ts;
    i_data.data      = data;
    i_data_val       = 1'b1;
  endtask

  // Hold the network packet until the interface accepts it (bounded).
  task automatic deliver(input string tag, input addr_t dest, input time_t ts,
                         input logic [31:0] data);
    logic acc;
    bit   ok;
    ok = 1'b0;
    set_rx(dest, ts, data);
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      acc = o_en;
      @(posedge clk);
      #1;
      ok = acc;
    end
    i_data_val = 1'b0;
    if (!ok) check(tag, 64'd0, 64'd1);
  endtask

  task automatic wait_time(input string tag, input time_t target);
    int unsigned waited;
    waited = 0;
    while (tb_time != target && waited < 200) begin
      step();
      waited++;
    end
    if (waited >= 200) check(tag, 64'd0, 64'd1);
  endtask

  initial begin
    i_inj_val  = 1'b0;
    i_inj_data = '0;
    i_en       = 1'b0;
    i_data     = '0;
    i_data_val = 1'b0;
    i_ej_rdy   = 1'b0;

    // Reset state
    #2;
    check("rst_data_val", o_data_val, 1'b0);
    check("rst_ej_val", o_ej_val, 1'b0);
    check("rst_data", o_data, '0);
    check("rst_ej_data", o_ej_data, '0);
    check("rst_tx_count", o_tx_count, 32'd0);
    check("rst_rx_count", o_rx_count, 32'd0);
    check("rst_misroute", o_misroute, 1'b0);
    check("rst_inj_rdy", o_inj_rdy, 1'b1);
    check("rst_en", o_en, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single injection at time 10, stamped and sent
    i_en = 1'b1;
    wait_time("t10_timeout", 16'd10);
    set_inj(8'd5, 32'h0000_00A5);
    step();
    i_inj_val = 1'b0;
    check("first_val", o_data_val, 1'b1);
    check("first_src", o_data.source, NID);
    check("first_ts", o_data.timestamp, 16'd10);
    check("first_data", o_data.data, 32'h0000_00A5);
    step();
    check("first_tx_count", o_tx_count, 32'd1);
    check("first_drained", o_data_val, 1'b0);

    // TX backpressure: fill 4, fifth blocked, then drain in order
    i_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_inj(8'd5, 32'h100 + k);
      step();
      if (k == 3) check("tx_full_rdy", o_inj_rdy, 1'b0);
    end
    step();
    i_inj_val = 1'b0;
    check("tx_stall_val", o_data_val, 1'b1);
    check("tx_stall_head", o_data.data, 32'h100);
    i_en = 1'b1;
    repeat (6) step();
    check("tx_drained", tx_q.size(), 0);
    check("tx_empty_val", o_data_val, 1'b0);
    check("tx_total", o_tx_count, 32'd5);

    // RX backpressure: fill 4, fifth held, sink resumes
    i_ej_rdy = 1'b0;
    for (int k = 0; k < 4; k++) deliver("rx_accept_timeout", NID, tb_time - 16'd2, 32'h200 + k);
    check("rx_full_en", o_en, 1'b0);
    set_rx(NID, 16'd7, 32'h204);
    repeat (3) step();
    check("rx_held_en", o_en, 1'b0);
    check("rx_held_count", o_rx_count, 32'd4);
    i_ej_rdy = 1'b1;
    deliver("rx_fifth_timeout", NID, 16'd7, 32'h204);
    repeat (6) step();
    check("rx_drained", rx_q.size(), 0);
    check("rx_empty_val", o_ej_val, 1'b0);
    check("rx_total", o_rx_count, 32'd5);

    // Latency across wrap, then misroute stickiness (after a fresh reset)
    #3 reset = 1'b1;
    step();
    reset = 1'b0;
    wait_time("t2_timeout", 16'd2);
    set_rx(NID, 16'hFFFE, 32'h300);
    step();
    i_data_val = 1'b0;
    check("wrap_latency", o_last_latency, 16'd4);
    check("wrap_misroute", o_misroute, 1'b0);
    deliver("misroute_timeout", 8'd7, tb_time, 32'h301);
    check("misroute_set", o_misroute, 1'b1);
    repeat (5) step();
    check("misroute_sticky", o_misroute, 1'b1);

    // Asynchronous reset with traffic queued both ways
    i_en     = 1'b0;
    i_ej_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_inj(8'd4, 32'h400 + k);
      step();
    end
    i_inj_val = 1'b0;
    for (int k = 0; k < 2; k++) deliver("pre_rst_timeout", NID, tb_time, 32'h500 + k);
    check("pre_rst_data_val", o_data_val, 1'b1);
    check("pre_rst_ej_val", o_ej_val, 1'b1);
    i_en     = 1'b1;
    i_ej_rdy = 1'b1;
    #3 reset = 1'b1;
    #1;
    check("arst_data_val", o_data_val, 1'b0);
    check("arst_ej_val", o_ej_val, 1'b0);
    check("arst_data", o_data, '0);
    check("arst_ej_data", o_ej_data, '0);
    check("arst_tx_count", o_tx_count, 32'd0);
    check("arst_rx_count", o_rx_count, 32'd0);
    check("arst_misroute", o_misroute, 1'b0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_inj_rdy", o_inj_rdy, 1'b1);
    check("post_rst_en", o_en, 1'b1);
    check("post_rst_data_val", o_data_val, 1'b0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
